// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the five-stage MIPS pipeline.
// Owns the fetch PC, talks to a variable-latency instruction memory and
// holds the IF/ID register. One delay slot: a redirect takes effect after
// the instruction currently being fetched has completed.
//
// Handshake: imem_req/imem_addr form a request that is held stable until
// imem_ready is seen high in the same cycle; imem_rdata is only consumed in
// a cycle where imem_req and imem_ready are both high.
//
// Optional feature macro: FETCH_ALIGN_CHK_EN
//   defined   -> a misaligned pc_F completes internally as a nop with adel_D=1
//   undefined -> redirect targets are word-aligned and adel_D is tied 0
//
// state_dbg exposes the FSM state (0 = FETCH, 1 = HOLD).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        npc_sel_D,
    input  logic        stall,
    input  logic        flush_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_D,
    output logic [31:0] PC4_D,
    output logic [31:0] instr_D,
    output logic        valid_D,
    output logic        adel_D,
    output logic        state_dbg
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc_f;
    logic [31:0] hold_instr;
    logic        redir_valid;
    logic [31:0] redir_tgt;

    logic        misaligned;
    logic [31:0] npc_eff;
    logic [31:0] seq;
    logic [31:0] next_pc;
    logic        complete;
    logic        bubble;
    logic [31:0] wr_instr;

`ifdef FETCH_ALIGN_CHK_EN
    logic adel_q;
`endif

    // Next-PC selection and per-cycle completion decode
    always_comb begin
        seq = pc_f + 32'd4;
`ifdef FETCH_ALIGN_CHK_EN
        misaligned = (state == FETCH) && (pc_f[1:0] != 2'b00);
        npc_eff    = npc;
`else
        misaligned = 1'b0;
        npc_eff    = npc & 32'hFFFF_FFFC;
`endif
        if (redir_valid)
            next_pc = redir_tgt;
        else if (npc_sel_D && !stall)
            next_pc = npc_eff;
        else
            next_pc = seq;

        complete = ((state == FETCH) && (imem_ready || misaligned) && !stall) ||
                   ((state == HOLD) && !stall);
        bubble   = (state == FETCH) && !imem_ready && !misaligned && !stall;

        if (state == HOLD)
            wr_instr = hold_instr;
        else if (misaligned)
            wr_instr = 32'h0;
        else
            wr_instr = imem_rdata;
    end

    // Fetch FSM, fetch PC, pending redirect and IF/ID register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc_f        <= RESET_PC;
            hold_instr  <= 32'h0;
            redir_valid <= 1'b0;
            redir_tgt   <= 32'h0;
            PC_D        <= 32'h0;
            PC4_D       <= 32'h0;
            instr_D     <= 32'h0;
            valid_D     <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            adel_q      <= 1'b0;
`endif
        end else begin
            // FSM and fetch PC
            case (state)
                FETCH: begin
                    if (complete) begin
                        pc_f <= next_pc;
                    end else if (stall && imem_ready && !misaligned) begin
                        // response arrived while D is stalled: park it
                        hold_instr <= imem_rdata;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_f  <= next_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase

            // A redirect that cannot be applied this cycle is remembered
            if (complete)
                redir_valid <= 1'b0;
            else if (npc_sel_D && !stall) begin
                redir_valid <= 1'b1;
                redir_tgt   <= npc_eff;
            end

            // IF/ID: flush wins over any write and over stall
            if (flush_D) begin
                instr_D <= 32'h0;
                valid_D <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                adel_q  <= 1'b0;
`endif
            end else if (complete) begin
                PC_D    <= pc_f;
                PC4_D   <= seq;
                instr_D <= wr_instr;
                valid_D <= 1'b1;
`ifdef FETCH_ALIGN_CHK_EN
                adel_q  <= misaligned;
`endif
            end else if (bubble) begin
                instr_D <= 32'h0;
                valid_D <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
                adel_q  <= 1'b0;
`endif
            end
        end
    end

    assign imem_req  = (state == FETCH) && rst_n && !misaligned;
    assign imem_addr = pc_f;
    assign state_dbg = (state == HOLD);

`ifdef FETCH_ALIGN_CHK_EN
    assign adel_D = adel_q;
`else
    assign adel_D = 1'b0;
`endif

endmodule
